// File: rtl/multi_source_recovery_manager_pkg.sv
// Shared recovery types: refetch-type and phase enums plus ActiveList age helpers.
package RecoveryTypes;

    typedef enum logic [2:0] {
        REFETCH_THIS_PC       = 3'd0,
        REFETCH_NEXT_PC       = 3'd1,
        REFETCH_BRANCH_TARGET = 3'd2,
        REFETCH_STORE_NEXT_PC = 3'd3,
        REFETCH_THIS_PC_CSR   = 3'd4,
        REFETCH_NEXT_PC_CSR   = 3'd5
    } RecoveryRefetchType;

    typedef enum logic [1:0] {
        PHASE_COMMIT       = 2'd0,
        PHASE_RECOVER_0    = 2'd1,
        PHASE_RECOVER_WAIT = 2'd2
    } RecoveryPhase;

    // Widest ActiveList index the age helpers handle; narrower indices are zero-extended.
    localparam int AGE_MAX_W = 16;

    function automatic RecoveryRefetchType decodeRefetchType(input logic [2:0] code);
        RecoveryRefetchType t;
        case (code)
            3'd1:    t = REFETCH_NEXT_PC;
            3'd2:    t = REFETCH_BRANCH_TARGET;
            3'd3:    t = REFETCH_STORE_NEXT_PC;
            3'd4:    t = REFETCH_THIS_PC_CSR;
            3'd5:    t = REFETCH_NEXT_PC_CSR;
            default: t = REFETCH_THIS_PC;
        endcase
        return t;
    endfunction

    function automatic logic [AGE_MAX_W-1:0] calcAge(input logic [AGE_MAX_W-1:0] ptr,
                                                     input logic [AGE_MAX_W-1:0] head,
                                                     input int unsigned width);
        logic [AGE_MAX_W-1:0] mask;
        mask = (AGE_MAX_W'(1) << width) - AGE_MAX_W'(1);
        return (ptr - head) & mask;
    endfunction

    function automatic logic isOlder(input logic [AGE_MAX_W-1:0] ptrA,
                                     input logic [AGE_MAX_W-1:0] ptrB,
                                     input logic [AGE_MAX_W-1:0] head,
                                     input int unsigned width);
        return calcAge(ptrA, head, width) < calcAge(ptrB, head, width);
    endfunction

endpackage

// File: rtl/multi_source_recovery_manager_arbiter.sv
// Combinational oldest-request picker: smallest ActiveList age wins, ties go to the lowest channel.
module recovery_age_arbiter
    import RecoveryTypes::*;
#(
    parameter int NUM_SRC  = 3,
    parameter int AL_IDX_W = 6
) (
    input  logic [NUM_SRC-1:0]          reqValid_i,
    input  logic [NUM_SRC*AL_IDX_W-1:0] reqPtr_i,
    input  logic [AL_IDX_W-1:0]         head_i,
    output logic                        anyValid_o,
    output logic [NUM_SRC-1:0]          grant_o,
    output logic [$clog2(NUM_SRC)-1:0]  winIdx_o
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic                found;
    logic [AL_IDX_W-1:0] bestPtr;
    logic [AL_IDX_W-1:0] curPtr;

    always_comb begin
        found    = 1'b0;
        bestPtr  = '0;
        curPtr   = '0;
        winIdx_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            curPtr = reqPtr_i[i*AL_IDX_W +: AL_IDX_W];
            if (reqValid_i[i] && (!found ||
                isOlder(AGE_MAX_W'(curPtr), AGE_MAX_W'(bestPtr), AGE_MAX_W'(head_i), AL_IDX_W))) begin
                found    = 1'b1;
                bestPtr  = curPtr;
                winIdx_o = SEL_W'(i);
            end
        end
        anyValid_o = found;
        grant_o    = found ? (NUM_SRC'(1) << winIdx_o) : '0;
    end

endmodule

// File: rtl/multi_source_recovery_manager.sv
// Recovery manager: registers the oldest recovery request, drives refetch PC and flush range,
// then waits for rename/issue to drain. Optional per-type counters: RSD_RECOVERY_EVENT_COUNT_EN.
module multi_source_recovery_manager
    import RecoveryTypes::*;
#(
    parameter int NUM_SRC         = 3,
    parameter int AL_IDX_W        = 6,
    parameter int PC_W            = 32,
    parameter int MIN_RECOVER_CYC = 2,
    parameter int INSN_BYTES      = 4
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [NUM_SRC-1:0]          reqValid,
    input  logic [NUM_SRC*3-1:0]        reqType,
    input  logic [NUM_SRC*PC_W-1:0]     reqPC,
    input  logic [NUM_SRC*AL_IDX_W-1:0] reqPtr,
    input  logic [AL_IDX_W-1:0]         alHeadPtr,
    input  logic [AL_IDX_W-1:0]         alTailPtr,
    input  logic [PC_W-1:0]             csrTargetPC,
    input  logic                        rmtBusy,
    input  logic                        iqBusy,
    output logic [1:0]                  phase,
    output logic                        toRecovery,
    output logic                        toCommit,
    output logic [NUM_SRC-1:0]          grant,
    output logic [PC_W-1:0]             recoveredPC,
    output logic [AL_IDX_W-1:0]         flushHead,
    output logic [AL_IDX_W-1:0]         flushTail,
    output logic                        csrTrigger,
    output logic                        unableToStart,
    output logic                        restarted
`ifdef RSD_RECOVERY_EVENT_COUNT_EN
    ,
    output logic [6*16-1:0]             evtCount
`endif
);
    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MIN_RECOVER_CYC + 1);

    RecoveryPhase        phase_q, phase_d;
    RecoveryRefetchType  type_q, type_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [AL_IDX_W-1:0] ptr_q, ptr_d;
    logic [AL_IDX_W-1:0] flushHead_q, flushHead_d;
    logic [AL_IDX_W-1:0] flushTail_q, flushTail_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                restarted_q, restarted_d;

    logic                anyValid;
    logic [NUM_SRC-1:0]  arbGrant;
    logic [SEL_W-1:0]    winIdx;
    RecoveryRefetchType  winType;
    logic [AL_IDX_W-1:0] winPtr;
    logic [PC_W-1:0]     winPC;
    logic                olderThanCurrent;
    logic                isCsr;
    logic                accept;

    recovery_age_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .AL_IDX_W (AL_IDX_W)
    ) u_arbiter (
        .reqValid_i (reqValid),
        .reqPtr_i   (reqPtr),
        .head_i     (alHeadPtr),
        .anyValid_o (anyValid),
        .grant_o    (arbGrant),
        .winIdx_o   (winIdx)
    );

    assign winType = decodeRefetchType(reqType[winIdx*3 +: 3]);
    assign winPtr  = reqPtr[winIdx*AL_IDX_W +: AL_IDX_W];
    assign winPC   = reqPC[winIdx*PC_W +: PC_W];
    // Age is re-measured against the live head so a retiring head cannot misorder the compare.
    assign olderThanCurrent = anyValid &&
        isOlder(AGE_MAX_W'(winPtr), AGE_MAX_W'(ptr_q), AGE_MAX_W'(alHeadPtr), AL_IDX_W);
    assign isCsr = (type_q == REFETCH_THIS_PC_CSR) || (type_q == REFETCH_NEXT_PC_CSR);

    always_comb begin
        phase_d     = phase_q;
        type_d      = type_q;
        pc_d        = pc_q;
        ptr_d       = ptr_q;
        flushHead_d = flushHead_q;
        flushTail_d = flushTail_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        restarted_d = 1'b0;
        toRecovery  = 1'b0;
        toCommit    = 1'b0;
        csrTrigger  = 1'b0;
        recoveredPC = '0;
        accept      = 1'b0;
        case (phase_q)
            PHASE_COMMIT: accept = anyValid;
            PHASE_RECOVER_0: begin
                toRecovery = 1'b1;
                csrTrigger = isCsr;
                case (type_q)
                    REFETCH_NEXT_PC, REFETCH_STORE_NEXT_PC: recoveredPC = pc_q + PC_W'(INSN_BYTES);
                    REFETCH_THIS_PC_CSR, REFETCH_NEXT_PC_CSR: recoveredPC = csrTargetPC;
                    default: recoveredPC = pc_q;
                endcase
                phase_d = PHASE_RECOVER_WAIT;
                cnt_d   = CNT_W'(MIN_RECOVER_CYC - 1);
            end
            PHASE_RECOVER_WAIT: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (olderThanCurrent) begin
                    accept      = 1'b1;
                    restarted_d = 1'b1;
                end else if (cnt_q == '0 && !rmtBusy && !iqBusy) begin
                    toCommit = 1'b1;
                    phase_d  = PHASE_COMMIT;
                end
            end
            default: phase_d = PHASE_COMMIT;
        endcase
        if (accept) begin
            phase_d     = PHASE_RECOVER_0;
            type_d      = winType;
            pc_d        = winPC;
            ptr_d       = winPtr;
            grant_d     = arbGrant;
            flushTail_d = alTailPtr;
            flushHead_d = (winType == REFETCH_THIS_PC || winType == REFETCH_THIS_PC_CSR) ?
                          winPtr : winPtr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            phase_q     <= PHASE_COMMIT;
            type_q      <= REFETCH_THIS_PC;
            pc_q        <= '0;
            ptr_q       <= '0;
            flushHead_q <= '0;
            flushTail_q <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            restarted_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            type_q      <= type_d;
            pc_q        <= pc_d;
            ptr_q       <= ptr_d;
            flushHead_q <= flushHead_d;
            flushTail_q <= flushTail_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            restarted_q <= restarted_d;
        end
    end

    assign phase         = phase_q;
    assign grant         = grant_q;
    assign flushHead     = flushHead_q;
    assign flushTail     = flushTail_q;
    assign restarted     = restarted_q;
    assign unableToStart = (phase_q != PHASE_COMMIT) || rmtBusy || iqBusy;

`ifdef RSD_RECOVERY_EVENT_COUNT_EN
    logic [5:0][15:0] evt_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            evt_q <= '0;
        end else if (phase_q == PHASE_RECOVER_0 && evt_q[type_q] != 16'hFFFF) begin
            evt_q[type_q] <= evt_q[type_q] + 16'd1;
        end
    end

    assign evtCount = evt_q;
`endif

    // Channel 0 is the RW stage, which never raises CSR refetches.
    assert property (@(posedge clk) disable iff (!rstN) !(toRecovery && toCommit));
    assert property (@(posedge clk) disable iff (!rstN)
        !(reqValid[0] && (reqType[2:0] == 3'd4 || reqType[2:0] == 3'd5)));

endmodule
